// File: rtl/pattern_det_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// controller state encoding and the pattern-length validity rule.
package pattern_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A length can be armed only if it selects at least one bit and fits the pattern register.
  function automatic logic len_valid(input int len, input int pat_w);
    return (len >= 1) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/pattern_det_core.sv
// Mealy detection engine: history shift register, fill counter and the
// compare of the newest len bits (history plus the live bit) against the pattern.
module pattern_det_core
  import pattern_det_pkg::*;
#(
  parameter int PAT_W = 5,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             overlap,
  input  logic             signal,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             match
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W:0]   window_s;
  logic [PAT_W:0]   pat_ext_s;
  logic [PAT_W:0]   mask_s;
  logic             fill_ok_s;

  // Match compare; window bit len-1 is the oldest bit of the candidate, aligned with pattern[len-1].
  always_comb begin
    window_s  = {hist_q, signal};
    pat_ext_s = {1'b0, pattern};
    mask_s    = '0;
    for (int i = 0; i <= PAT_W; i++) begin
      mask_s[i] = (i < int'(len));
    end
    fill_ok_s = ({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len};
    match     = fill_ok_s && (((window_s ^ pat_ext_s) & mask_s) == '0);
  end

  // History/fill next state: a non-overlapping match restarts the search from empty.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (match && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window_s[PAT_W-1:0];
        if (fill_q < LEN_W'(PAT_W)) begin
          fill_d = fill_q + LEN_W'(1);
        end else begin
          fill_d = fill_q;
        end
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // History and fill registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Pattern-detection controller: configuration registers, IDLE/RUN/DONE FSM
// and saturating match counter around the pattern_det_core engine.
module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 5'b11011,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             signal,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             busy_q, done_q;
  logic             match_s;
  logic             len_ok_s;
  logic             enter_run_s;
  logic             run_s;
  logic             hit_s;

  assign len_ok_s    = len_valid(32'(len_q), PAT_W);
  assign run_s       = (state_q == ST_RUN);
  assign hit_s       = run_s && match_s && !abort;
  assign cnt_inc_s   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign enter_run_s = (state_q != ST_RUN) && (state_d == ST_RUN);

  pattern_det_core #(
    .PAT_W (PAT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clear   (enter_run_s),
    .en      (run_s && !abort),
    .overlap (ovl_q),
    .signal  (signal),
    .pattern (pat_q),
    .len     (len_q),
    .match   (match_s)
  );

  // State register; busy/done are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Next-state logic; abort beats both a match and a restart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok_s) state_d = ST_RUN;
        else                   state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (abort)                                                      state_d = ST_IDLE;
        else if (match_s && (tgt_q != '0) && (cnt_inc_s == tgt_q))      state_d = ST_DONE;
        else                                                            state_d = ST_RUN;
      end
      ST_DONE: begin
        if (abort)                  state_d = ST_IDLE;
        else if (start && len_ok_s) state_d = ST_RUN;
        else                        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: zero-latency match indication and next counter value.
  always_comb begin
    out   = 1'b0;
    cnt_d = cnt_q;
    if (hit_s) out = 1'b1;
    else       out = 1'b0;
    if (enter_run_s) cnt_d = '0;
    else if (hit_s)  cnt_d = cnt_inc_s;
    else             cnt_d = cnt_q;
  end

  // Match counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Configuration registers, writable only while detection is not running.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q <= RST_PAT;
      len_q <= LEN_W'(PAT_W);
      ovl_q <= 1'b0;
      tgt_q <= '0;
    end else if (cfg_we && !run_s) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
      tgt_q <= cfg_target;
    end else begin
      pat_q <= pat_q;
      len_q <= len_q;
      ovl_q <= ovl_q;
      tgt_q <= tgt_q;
    end
  end

  assign match_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
